mpmc11_cmd_sequencer: RTL

//  Sequences one granted channel transaction through the mpmc11 memory state machine.

---
 rtl/mpmc11_pkg.sv | 15 +
 rtl/mpmc11_timeout_counter.sv | 16 +
 rtl/mpmc11_cmd_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/mpmc11_pkg.sv
// mpmc11_pkg: shared state encoding and DRAM command codes for the mpmc11 controller
package mpmc11_pkg;
  typedef enum logic [2:0] {
    IDLE,
    PRESET1,
    PRESET2,
    PRESET3,
    WRITE_DATA0,
    WRITE_DATA1,
    READ_DATA0,
    READ_DATA1
  } mpmc11_state_t;
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;
endpackage

// File: rtl/mpmc11_timeout_counter.sv
// mpmc11_timeout_counter: counts enabled cycles since the last clear and flags the TMO-th one
module mpmc11_timeout_counter #(
  parameter int TMO = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TMO + 1);
  logic [W-1:0] cnt;
  assign expired = en && !clr && cnt == W'(TMO - 1);
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/mpmc11_cmd_sequencer.sv
// mpmc11_cmd_sequencer: walks one granted transaction through the preset, write and read phases
module mpmc11_cmd_sequencer
  import mpmc11_pkg::*;
#(
  parameter int BURST_WID = 6,
  parameter int TMO       = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 req_we,
  input  logic [BURST_WID-1:0] req_len,
  output logic                 req_ack,
  output mpmc11_state_t        state,
  input  logic                 mem_rdy,
  input  logic                 mem_wdf_rdy,
  input  logic                 mem_rd_valid,
  output logic                 mem_en,
  output logic [2:0]           mem_cmd,
  output logic                 mem_wdf_wren,
  output logic                 mem_wdf_end,
  output logic                 addr_inc,
  output logic                 rd_beat,
  output logic                 done,
  output logic                 err
);
  logic                 we_r;
  logic [BURST_WID-1:0] cmd_cnt;
  logic [BURST_WID-1:0] beat_cnt;
  logic                 rd_st;
  logic                 cmd_acc;
  logic                 beat;
  logic                 last_beat;
  logic                 last_wr;
  logic                 tmo_exp;
  assign rd_st        = state == READ_DATA0 || state == READ_DATA1;
  assign mem_en       = state == WRITE_DATA1 || state == READ_DATA0;
  assign mem_wdf_wren = state == WRITE_DATA0;
  assign mem_wdf_end  = mem_wdf_wren;
  assign cmd_acc      = mem_en && mem_rdy;
  assign beat         = rd_st && mem_rd_valid;
  assign last_beat    = beat && beat_cnt == '0;
  assign last_wr      = state == WRITE_DATA1 && mem_rdy && cmd_cnt == '0;
  mpmc11_timeout_counter #(.TMO(TMO)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (mem_rd_valid || state != READ_DATA1),
    .en      (state == READ_DATA1),
    .expired (tmo_exp)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      we_r     <= 1'b0;
      cmd_cnt  <= '0;
      beat_cnt <= '0;
      mem_cmd  <= CMD_WRITE;
      req_ack  <= 1'b0;
      addr_inc <= 1'b0;
      rd_beat  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      req_ack  <= state == IDLE && req;
      addr_inc <= cmd_acc;
      rd_beat  <= beat;
      done     <= last_wr || last_beat || tmo_exp;
      err      <= tmo_exp;
      if (beat && beat_cnt != '0)
        beat_cnt <= beat_cnt - 1'b1;
      case (state)
        IDLE:
          if (req) begin
            we_r     <= req_we;
            cmd_cnt  <= req_len;
            beat_cnt <= req_len;
            state    <= PRESET1;
          end
        PRESET1: state <= PRESET2;
        PRESET2: state <= PRESET3;
        PRESET3: begin
          mem_cmd <= we_r ? CMD_WRITE : CMD_READ;
          state   <= we_r ? WRITE_DATA0 : READ_DATA0;
        end
        WRITE_DATA0:
          if (mem_wdf_rdy)
            state <= WRITE_DATA1;
        WRITE_DATA1:
          if (mem_rdy) begin
            if (cmd_cnt == '0) begin
              state <= IDLE;
            end else begin
              cmd_cnt <= cmd_cnt - 1'b1;
              state   <= WRITE_DATA0;
            end
          end
        READ_DATA0:
          if (last_beat) begin
            state <= IDLE;
          end else if (mem_rdy) begin
            if (cmd_cnt == '0)
              state <= READ_DATA1;
            else
              cmd_cnt <= cmd_cnt - 1'b1;
          end
        READ_DATA1:
          if (last_beat || tmo_exp)
            state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
